// File: rtl/mdu_pkg.sv
// Shared encodings and sizes for the multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int CNT_W     = 6;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply over {acc, multiplier}
// or restoring divide over {rem, quotient}.
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [2*WIDTH-1:0] work,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] next_work
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_shift;

    always_comb begin
        sum       = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, operand} : '0);
        rem_shift = work[2*WIDTH-1:WIDTH-1];
        if (is_div) begin
            // The carry bit of the shifted remainder takes part in the compare.
            if (rem_shift >= {1'b0, operand})
                next_work = {rem_shift[WIDTH-1:0] - operand, work[WIDTH-2:0], 1'b1};
            else
                next_work = {rem_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
        end else begin
            next_work = {sum, work[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Optional MDU_FAST_ZERO_EN: skip iterations when an operand is zero.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] work;
    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   operand;
    logic               is_div;
    logic               sign_q;
    logic               sign_r;
    logic               div_zero;

    logic               op_div;
    logic               a_neg;
    logic               b_neg;
    logic               b_zero;
    logic               fast_skip;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign op_div = op[1];
    assign a_neg  = ~op[0] & operand_a[WIDTH-1];
    assign b_neg  = ~op[0] & operand_b[WIDTH-1];
    assign a_mag  = a_neg ? -operand_a : operand_a;
    assign b_mag  = b_neg ? -operand_b : operand_b;
    assign b_zero = (operand_b == '0);

`ifdef MDU_FAST_ZERO_EN
    assign fast_skip = (operand_a == '0) | b_zero;
`else
    assign fast_skip = 1'b0;
`endif

    // Divide by zero leaves |a| in the remainder; sign_r restores a as supplied.
    assign prod_fix = sign_q ? -work : work;
    assign quo_fix  = div_zero ? {WIDTH{1'b1}} :
                      (sign_q ? -work[WIDTH-1:0] : work[WIDTH-1:0]);
    assign rem_fix  = sign_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .work      (work),
        .operand   (operand),
        .is_div    (is_div),
        .next_work (step_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            work     <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        operand  <= op_div ? b_mag : a_mag;
                        is_div   <= op_div;
                        sign_q   <= a_neg ^ b_neg;
                        sign_r   <= a_neg;
                        div_zero <= op_div & b_zero;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        if (fast_skip) begin
                            state <= FIX;
                            work  <= {((op_div & b_zero) ? a_mag : {WIDTH{1'b0}}), {WIDTH{1'b0}}};
                        end else begin
                            state <= RUN;
                            work  <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        end
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    work <= step_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITERS - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
    import mdu_pkg::*;

`ifdef MDU_FAST_ZERO_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int lat, nbusy, npulse;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        lat = 0; nbusy = 0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int exp_lat);
        launch(o, a, b);
        wait_done();
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; operand_a = '0; operand_b = '0; wdata = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b0;

        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done();
        check("multu max latency", 32'(lat), 32'd33);
        check("multu max busy cycles", 32'(nbusy), 32'd33);
        check("multu max hi", hi, 32'hFFFFFFFE);
        check("multu max lo", lo, 32'h00000001);
        @(negedge clk);
        check("multu max done width", 32'(done), 32'd0);

        run("mult -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
        run("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run("divu 1000/7", OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 33);
        run("divu 100/0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, ZERO_LAT);
        run("div -7/0", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, ZERO_LAT);
        run("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
        run("mult 0*5", OP_MULT, 32'd0, 32'd5, 32'h0, 32'h0, ZERO_LAT);

        // Second start and mthi while busy must both be ignored.
        launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
        op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd3;
        start = 1'b1; mthi = 1'b1; wdata = 32'h1234;
        repeat (3) @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        wait_done();
        check("busy ignore latency", 32'(lat), 32'd30);
        check("busy ignore hi", hi, 32'hFFFFFFFF);
        check("busy ignore lo", lo, 32'hFFFFFFEB);
        @(negedge clk);

        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi idle hi", hi, 32'h1234);
        check("mthi idle lo", lo, 32'hFFFFFFEB);

        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi+mtlo hi", hi, 32'hA5A5A5A5);
        check("mthi+mtlo lo", lo, 32'hA5A5A5A5);

        op = OP_MULTU; operand_a = 32'd2; operand_b = 32'd3;
        start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        check("start+mthi busy", 32'(busy), 32'd1);
        check("start+mthi hi held", hi, 32'hA5A5A5A5);
        wait_done();
        check("start+mthi hi", hi, 32'h0);
        check("start+mthi lo", lo, 32'd6);
        @(negedge clk);

        mthi = 1'b1; wdata = 32'h77;
        @(negedge clk);
        mthi = 1'b0;
        launch(OP_DIVU, 32'd1000, 32'd7);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid reset hi", hi, 32'h0);
        check("mid reset lo", lo, 32'h0);
        check("mid reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        npulse = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) npulse++;
        end
        check("mid reset no done", 32'(npulse), 32'd0);
        check("mid reset idle busy", 32'(busy), 32'd0);

        run("divu 100/7 after reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file read ports: consumes ReadData1 (rs) and ReadData2 (rt) for MULT/MULTU/DIV/DIVU.
- HI/LO feed the MFHI/MFLO path back to the register file write port.
- Asserts busy so the control unit stalls dependent MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITERS, 32, shift-add / restoring-divide iterations; always equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  launch operation; sampled only while idle
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  input  WIDTH  rs value (multiplicand / dividend)
- operand_b  input  WIDTH  rt value (multiplier / divisor)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  MTHI/MTLO data
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
- States and transitions:
  - IDLE: start=1 at edge N latches the magnitudes of the operands. For signed ops, |x| is taken with two's-complement negate when the MSB is set. Also latches sign_q=a31^b31 and sign_r=a31 (unsigned ops: both 0), loads counter=0 and goes to RUN. busy=1 after edge N.
  - RUN: one iteration per cycle. Multiply is shift-add over a 64-bit {acc, multiplier} register. Divide is restoring over a 64-bit {rem, quotient} register. The counter increments each cycle. After the ITERS-th iteration the state goes to FIX.
  - FIX: applies sign correction. Multiply: negate the 64-bit product if sign_q. Divide: negate the quotient if sign_q and the remainder if sign_r. Writes HI (product[63:32] / remainder) and LO (product[31:0] / quotient). Goes to IDLE.
- Timing: HI/LO update, done=1 and busy=0 all occur at edge N+ITERS+1 (edge N+33 by default). done lasts exactly one cycle.
- Width rules: all arithmetic is modulo 2^64 internally. Results are truncated to HI/LO widths and never saturated.
- start while busy is ignored; operands are not re-sampled.
- mthi/mtlo:
  - While idle: the selected register is written at the next edge. mthi and mtlo may both be asserted and both are written.
  - While busy: ignored.
  - start together with mthi/mtlo in the same idle cycle: start is taken and mthi/mtlo are dropped.
- Divide by zero, no trap: HI=operand_a (as supplied), LO=32'hFFFFFFFF, normal latency. Under DIV the sign fix is bypassed for this case.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (natural wrap).
- Reset mid-operation: the operation is aborted, no HI/LO write, done is not pulsed.
- hi/lo are held stable during RUN. The old values stay readable until the FIX edge.

Optional Feature:
- Macro MDU_FAST_ZERO_EN.
- Defined: if at start either operand magnitude is 0 or the divisor is 0, RUN is skipped (IDLE->FIX). HI/LO/done then arrive at edge N+1 with the same result values.
- Undefined: fixed ITERS+1 latency for every operation.

Decomposition:
- Package mdu_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
  - state enum IDLE/RUN/FIX
  - constant MDU_WIDTH=32 and counter width localparam (6 bits)
- One sub-module, mdu_iter_step: combinational single iteration. Takes the 64-bit working register, the latched operand magnitude and an op-is-divide select; returns the next working register. The top level holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at edge N+33, HI=0xFFFFFFFE, LO=0x00000001, busy high 33 cycles.
- MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> HI=100, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Under busy:
  - second start with new operands, and mthi wdata=0x1234 -> both ignored, first result unchanged.
  - after done, mthi 0x1234 -> HI=0x1234 next edge, LO untouched.
- rst pulsed at iteration 10 of DIVU -> hi=lo=0, busy=0, no done pulse. A fresh start afterwards completes normally.
- With MDU_FAST_ZERO_EN, MULT 0*5 -> done at edge N+1, HI=LO=0. Without it -> done at N+33.
